// File: rtl/gomoku_engine.sv
// Gomoku placement engine: owns the board, checks each placement for legality,
// then scans the four lines through the new stone at a fixed cost per move.
module gomoku_engine #(
    parameter int BOARD_N     = 8,
    parameter int WIN_LEN     = 5,
    parameter int NUM_PLAYERS = 2,
    localparam int CW         = $clog2(BOARD_N),
    localparam int PW         = 2
) (
    input  logic          clock_i,
    input  logic          resetn_i,
    input  logic          put_i,
    input  logic [CW-1:0] coord_x_i,
    input  logic [CW-1:0] coord_y_i,
    input  logic [CW-1:0] rd_x_i,
    input  logic [CW-1:0] rd_y_i,
    output logic [PW-1:0] rd_cell_o,
    output logic [PW-1:0] turn_o,
    output logic          busy_o,
    output logic          accept_o,
    output logic          reject_o,
    output logic          game_over_o,
    output logic [PW-1:0] winner_o
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int NW    = $clog2(CELLS + 1);
    localparam int LW    = $clog2(2 * WIN_LEN);
    localparam int DW    = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, OVER} state_t;

    state_t        state_q;
    logic [PW-1:0] board_q [BOARD_N][BOARD_N];
    logic [CW-1:0] px_q, py_q;
    logic [PW-1:0] turn_q, winner_q;
    logic          accept_q, reject_q, gameOver_q;
    logic [NW-1:0] count_q;
    logic [1:0]    dir_q;
    logic          side_q;
    logic [DW-1:0] dist_q;
    logic          alive_q;
    logic [LW-1:0] lineLen_q [4];

    int            dx, dy, tx, ty;
    logic          inRange, runOn, alive_d, win, legal;
    logic [PW-1:0] probe;

    // Cell probed this scan cycle; a side's run dies at the first miss or the edge.
    always_comb begin
        dx = 0;
        dy = 0;
        case (dir_q)
            2'd0:    dy = 1;
            2'd1:    dx = 1;
            2'd2:    begin dx = 1; dy = 1;  end
            default: begin dx = 1; dy = -1; end
        endcase
        if (side_q) begin
            dx = -dx;
            dy = -dy;
        end
        tx      = int'(px_q) + dx * int'(dist_q);
        ty      = int'(py_q) + dy * int'(dist_q);
        inRange = (tx >= 0) && (tx < BOARD_N) && (ty >= 0) && (ty < BOARD_N);
        probe   = '0;
        if (inRange) probe = board_q[tx[CW-1:0]][ty[CW-1:0]];
        runOn   = (dist_q == DW'(1)) ? 1'b1 : alive_q;
        alive_d = runOn && inRange && (probe == turn_q);
    end

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 4; i++)
            if (int'(lineLen_q[i]) >= WIN_LEN) win = 1'b1;
    end

    always_comb begin
        legal     = 1'b0;
        rd_cell_o = '0;
        if (int'(coord_x_i) < BOARD_N && int'(coord_y_i) < BOARD_N)
            legal = (board_q[coord_x_i][coord_y_i] == '0);
        if (int'(rd_x_i) < BOARD_N && int'(rd_y_i) < BOARD_N)
            rd_cell_o = board_q[rd_x_i][rd_y_i];
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            for (int i = 0; i < BOARD_N; i++)
                for (int j = 0; j < BOARD_N; j++)
                    board_q[i][j] <= '0;
            px_q       <= '0;
            py_q       <= '0;
            turn_q     <= PW'(1);
            winner_q   <= '0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
            gameOver_q <= 1'b0;
            count_q    <= '0;
            dir_q      <= '0;
            side_q     <= 1'b0;
            dist_q     <= DW'(1);
            alive_q    <= 1'b0;
            for (int i = 0; i < 4; i++) lineLen_q[i] <= '0;
        end else begin
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (put_i && legal) begin
                        board_q[coord_x_i][coord_y_i] <= turn_q;
                        px_q     <= coord_x_i;
                        py_q     <= coord_y_i;
                        accept_q <= 1'b1;
                        if (int'(count_q) < CELLS) count_q <= count_q + 1'b1;
                        dir_q    <= '0;
                        side_q   <= 1'b0;
                        dist_q   <= DW'(1);
                        for (int i = 0; i < 4; i++) lineLen_q[i] <= LW'(1);
                        state_q  <= SCAN;
                    end else if (put_i) begin
                        reject_q <= 1'b1;
                    end
                end
                // Step order: direction, then side, then distance; always the full count.
                SCAN: begin
                    alive_q <= alive_d;
                    if (alive_d) lineLen_q[dir_q] <= lineLen_q[dir_q] + 1'b1;
                    if (int'(dist_q) == WIN_LEN - 1) begin
                        dist_q <= DW'(1);
                        side_q <= ~side_q;
                        if (side_q) begin
                            dir_q <= dir_q + 1'b1;
                            if (dir_q == 2'd3) state_q <= RESOLVE;
                        end
                    end else begin
                        dist_q <= dist_q + 1'b1;
                    end
                end
                RESOLVE: begin
                    if (win) begin
                        gameOver_q <= 1'b1;
                        winner_q   <= turn_q;
                        state_q    <= OVER;
                    end else if (int'(count_q) == CELLS) begin
                        gameOver_q <= 1'b1;
                        winner_q   <= '0;
                        state_q    <= OVER;
                    end else begin
                        turn_q  <= (turn_q == PW'(NUM_PLAYERS)) ? PW'(1) : turn_q + 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign turn_o      = turn_q;
    assign busy_o      = (state_q == SCAN) || (state_q == RESOLVE);
    assign accept_o    = accept_q;
    assign reject_o    = reject_q;
    assign game_over_o = gameOver_q;
    assign winner_o    = winner_q;

endmodule

// File: doc/gomoku_engine.md
GOMOKU_ENGINE -- requirements
Module: gomoku_engine

Interface
REQ-001 Parameter BOARD_N, default 8: board is BOARD_N x BOARD_N cells, legal range 5..15.
REQ-002 Parameter WIN_LEN, default 5: stones in a row needed to win, legal range 3..BOARD_N.
REQ-003 Parameter NUM_PLAYERS, default 2: number of players, legal range 2..3.
REQ-004 Derived widths: CW = clog2(BOARD_N) for coordinates; PW = 2 for player/cell codes (0 = empty, 1..NUM_PLAYERS = stone).
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 resetn  in  1  synchronous, active-low reset.
REQ-007 put  in  1  one-cycle placement strobe, active high.
REQ-008 coord_x, coord_y  in  CW each  row and column of the placement.
REQ-009 rd_x, rd_y  in  CW each  display read address.
REQ-010 rd_cell  out  PW  combinational contents of cell (rd_x, rd_y); 0 if the address is out of range.
REQ-011 turn  out  PW  player to move, 1..NUM_PLAYERS.
REQ-012 busy  out  1  high while a placement is being evaluated.
REQ-013 accept, reject  out  1 each  one-cycle placement result pulses.
REQ-014 game_over  out  1  game finished; winner  out  PW  winning player, or 0 for a draw.

Function
REQ-015 States: IDLE, SCAN, RESOLVE, OVER; busy = (state is SCAN or RESOLVE).
REQ-016 Legal put in IDLE: coordinates < BOARD_N and target cell empty.
REQ-017 On edge k with put=1 in IDLE and a legal put: the engine writes turn into the cell, enters SCAN, and drives accept=1 for exactly the cycle after edge k.
REQ-018 On an illegal put in IDLE: the board is unchanged, the state stays IDLE, reject=1 for one cycle, and turn is unchanged.
REQ-019 put in SCAN, RESOLVE or OVER is ignored: no accept, no reject, no state change.
REQ-020 SCAN lasts exactly S = 8*(WIN_LEN-1) cycles: 4 directions (row, column, diagonal, anti-diagonal) x 2 sides x (WIN_LEN-1) steps, one cell per cycle, in a fixed order.
REQ-021 Each side's run stops extending at the board edge or at the first cell not equal to the placed stone; the step counter keeps running regardless, so latency is data-independent.
REQ-022 Direction line = 1 + left run + right run; a win occurs if any line >= WIN_LEN (overlines win).
REQ-023 RESOLVE takes one cycle; result outputs update at edge k+S+1 (k+33 with default parameters).
REQ-024 Result on a win: game_over=1, winner=placing player, state goes to OVER.
REQ-025 Result on no win with all BOARD_N^2 cells occupied: game_over=1, winner=0, state goes to OVER.
REQ-026 Result otherwise: turn advances (NUM_PLAYERS wraps to 1), state returns to IDLE.
REQ-027 The occupied-cell counter is width clog2(BOARD_N^2+1), increments only on accept, and never wraps.
REQ-028 OVER is left only by reset.

Reset
REQ-029 resetn=0 at any edge, including mid-SCAN, clears all cells to 0, state=IDLE, turn=1, and busy=accept=reject=game_over=winner=0, with the occupied-cell counter cleared.
REQ-030 A put asserted in the same cycle as resetn=0 is discarded.

Verification
REQ-031 Reset, put (3,3) -> accept one cycle later, busy for 33 cycles, turn=2, rd_cell(3,3)=1.
REQ-032 Put (3,3) twice -> second put gives reject=1, turn unchanged at 2, board unchanged.
REQ-033 P1 plays (0,0)..(0,4) while P2 plays (7,0)..(7,3) -> after the 9th put: game_over=1, winner=1, further puts ignored.
REQ-034 Anti-diagonal P2 win (4,0),(3,1),(2,2),(1,3),(0,4) with NUM_PLAYERS=3 -> winner=2 after turn order 1,2,3 cycles correctly.
REQ-035 BOARD_N=5, WIN_LEN=5 with a non-winning fill of 25 cells -> game_over=1, winner=0.
REQ-036 Reset pulse at SCAN cycle 10 -> all cells read 0, turn=1, and the next legal put is accepted.
